div_seq: RTL

- Multi-cycle divider sequencer for the EX stage of the 5-stage MIPS pipeline.
- Accepts DIV/DIVU operands that the decode stage has resolved, including forwarding.
- Runs a 32-iteration restoring-division state machine and returns {remainder, quotient} for the HI/LO write.
- Exposes busy_o so the pipeline stall controller can hold IF/ID/EX while a divide is in flight.

---
 rtl/div_seq_pkg.sv | 21 ++
 rtl/div_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/div_seq_pkg.sv
// Shared encodings and constants for the multi-cycle EX-stage divider.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam int unsigned CNT_W = 6;
    localparam int unsigned DIV_CNT = 32;

    localparam logic DIV_START          = 1'b1;
    localparam logic DIV_STOP           = 1'b0;
    localparam logic DIV_RESULT_READY   = 1'b1;
    localparam logic DIV_RESULT_NOT_RDY = 1'b0;
    localparam logic DIV_ANNUL          = 1'b1;
    localparam logic DIV_NOT_ANNUL      = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Restoring-division sequencer for DIV/DIVU: one quotient bit per cycle,
// then a sign fixup cycle that produces {remainder, quotient} for HI/LO.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    localparam int unsigned WW = 2 * DATA_W + 1;

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WW-1:0]          w_q, w_d;
    logic [DATA_W-1:0]      d_q, d_d;
    logic                   s1_q, s1_d;
    logic                   s2_q, s2_d;
    logic                   sgn_q, sgn_d;
    logic [2*DATA_W-1:0]    result_q, result_d;
    logic                   ready_q, ready_d;

    logic [DATA_W:0]        trial;
    logic [DATA_W-1:0]      q_fix;
    logic [DATA_W-1:0]      r_fix;

    // Magnitude of a two's-complement operand when dividing signed.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x,
                                              input logic              sg);
        return (sg && x[DATA_W-1]) ? (DATA_W'(0) - x) : x;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            w_q      <= '0;
            d_q      <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_RDY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            d_q      <= d_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        d_d      = d_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        sgn_d    = sgn_q;
        result_d = result_q;
        ready_d  = ready_q;

        // Trial subtract of the shifted partial remainder against the divisor.
        trial = {1'b0, w_q[2*DATA_W-1:DATA_W]} - {1'b0, d_q};

        q_fix = w_q[DATA_W-1:0];
        r_fix = w_q[2*DATA_W:DATA_W+1];
        if (sgn_q && (s1_q ^ s2_q)) q_fix = DATA_W'(0) - q_fix;
        if (sgn_q && s1_q)          r_fix = DATA_W'(0) - r_fix;

        unique case (state_q)
            DIV_FREE: begin
                if (start_i == DIV_START && annul_i == DIV_NOT_ANNUL) begin
                    s1_d  = opdata1_i[DATA_W-1];
                    s2_d  = opdata2_i[DATA_W-1];
                    sgn_d = signed_div_i;
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        d_d     = mag(opdata2_i, signed_div_i);
                        // Dividend sits one bit up so the first trial sees its MSB.
                        w_d     = {DATA_W'(0), mag(opdata1_i, signed_div_i), 1'b0};
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i == DIV_ANNUL) begin
                    state_d = DIV_FREE;
                end else begin
                    w_d      = '0;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i == DIV_ANNUL) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_RDY;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    if (trial[DATA_W]) begin
                        w_d = {w_q[2*DATA_W-1:0], 1'b0};
                    end else begin
                        w_d = {trial[DATA_W-1:0], w_q[DATA_W-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {r_fix, q_fix};
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_RDY;
                    result_d = '0;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == DIV_BY_ZERO) || (state_q == DIV_ON);

endmodule
